// File: rtl/game_pkg.sv
// Shared game-flow definitions: the one-hot game state used by the turn
// sequencer and the enemy block, plus default timing parameters.
package game_pkg;

  // One-hot game state; exactly one bit is ever set on the state bus.
  typedef enum logic [3:0] {
    ST_TITLE   = 4'b0001,
    ST_PLAYER  = 4'b0010,
    ST_RESOLVE = 4'b0100,
    ST_ENEMY   = 4'b1000
  } game_state_t;

  // Turn counter is 4 bits wide, so at most 16 distinct turns.
  localparam int DEF_MAX_TURNS      = 16;
  // Frame pulses spent resolving a move before deciding the outcome.
  localparam int DEF_RESOLVE_FRAMES = 30;
  // Frame pulses the enemy phase may last before the watchdog ends it.
  localparam int DEF_TIMEOUT_FRAMES = 120;

endpackage : game_pkg

// File: rtl/turn_sequencer_frame_counter.sv
// Frame pulse counter with synchronous clear and a terminal-count strobe.
// The strobe fires on the frame pulse that brings the count to LIMIT; the
// count then holds at LIMIT until cleared so it can never fire twice.
module frame_counter #(
  parameter int LIMIT = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic new_frame_in,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] TOP  = CW'(LIMIT);

  logic [CW-1:0] count_q;
  logic          pulse;

  assign pulse = enable & new_frame_in;

  // Count enabled frame pulses, saturating at LIMIT; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (pulse && (count_q != TOP)) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tc = pulse && (count_q == LAST);

endmodule : frame_counter

// File: rtl/turn_sequencer.sv
// Game-flow controller feeding the enemy renderer/AI block. Requests for a
// new game state are latched into a pending slot and only applied on the
// next frame pulse, so no frame is ever rendered with a mixed state.
module turn_sequencer
  import game_pkg::*;
#(
  parameter int MAX_TURNS      = DEF_MAX_TURNS,
  parameter int RESOLVE_FRAMES = DEF_RESOLVE_FRAMES,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame_in,
  input  logic       start_btn_in,
  input  logic       move_valid_in,
  input  logic       rotate_btn_in,
  input  logic       player_dead_in,
  input  logic       enemy_busy_in,
  input  logic       enemy_finished_in,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic [1:0] rotate_out,
  output logic       game_over_out,
  output logic       timeout_out
);

  localparam logic [3:0] TURN_LAST = 4'(MAX_TURNS - 1);

  game_state_t state_q;
  game_state_t next_q;
  logic        pending_q;
  logic [3:0]  turn_q;
  logic [1:0]  rot_q;
  logic        game_over_q;
  logic        timeout_q;
  logic        start_q;
  logic        busy_seen_unused_q;

  logic        apply;
  logic        start_rise;
  logic        resolve_tc;
  logic        watchdog_tc;

  // Turn number wraps from MAX_TURNS-1 back to zero.
  function automatic logic [3:0] turn_advance(input logic [3:0] t);
    return (t == TURN_LAST) ? 4'd0 : t + 4'd1;
  endfunction

  // A pending request only takes effect on a frame pulse seen after it was
  // latched; a pulse in the latching cycle itself sees pending_q still low.
  assign apply      = pending_q & new_frame_in;
  assign start_rise = start_btn_in & ~start_q;

  // Both counters restart whenever a new state is entered.
  frame_counter #(.LIMIT(RESOLVE_FRAMES)) u_resolve_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (apply),
    .enable       (state_q == ST_RESOLVE),
    .new_frame_in (new_frame_in),
    .tc           (resolve_tc)
  );

  frame_counter #(.LIMIT(TIMEOUT_FRAMES)) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .clear        (apply),
    .enable       (state_q == ST_ENEMY),
    .new_frame_in (new_frame_in),
    .tc           (watchdog_tc)
  );

  // Start-button history; resets high so a button held through reset
  // must be released and pressed again to start a game.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b1;
    end else begin
      start_q <= start_btn_in;
    end
  end

  // Enemy busy is kept for visibility only; it never steers the sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_seen_unused_q <= 1'b0;
    end else begin
      busy_seen_unused_q <= enemy_busy_in;
    end
  end

  // Game FSM: apply the pending request on a frame, otherwise look for a
  // new request in the current state while the pending slot is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_TITLE;
      next_q      <= ST_TITLE;
      pending_q   <= 1'b0;
      turn_q      <= 4'd0;
      rot_q       <= 2'd0;
      game_over_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (apply) begin
      state_q   <= next_q;
      pending_q <= 1'b0;
      if (state_q == ST_TITLE) begin
        // Fresh game: wipe everything left over from the previous one.
        turn_q      <= 4'd0;
        rot_q       <= 2'd0;
        game_over_q <= 1'b0;
        timeout_q   <= 1'b0;
      end else if (state_q == ST_ENEMY) begin
        turn_q <= turn_advance(turn_q);
      end
    end else if (!pending_q) begin
      unique case (state_q)
        ST_TITLE: begin
          if (start_rise) begin
            next_q    <= ST_PLAYER;
            pending_q <= 1'b1;
          end
        end
        ST_PLAYER: begin
          // Rotate and move in the same cycle both take effect.
          if (rotate_btn_in) begin
            rot_q <= rot_q + 2'd1;
          end
          if (move_valid_in) begin
            next_q    <= ST_RESOLVE;
            pending_q <= 1'b1;
          end
        end
        ST_RESOLVE: begin
          if (resolve_tc) begin
            pending_q <= 1'b1;
            if (player_dead_in) begin
              game_over_q <= 1'b1;
              next_q      <= ST_TITLE;
            end else begin
              next_q <= ST_ENEMY;
            end
          end
        end
        ST_ENEMY: begin
          // A finish report wins over a simultaneous watchdog expiry.
          if (enemy_finished_in) begin
            next_q    <= ST_PLAYER;
            pending_q <= 1'b1;
          end else if (watchdog_tc) begin
            timeout_q <= 1'b1;
            next_q    <= ST_PLAYER;
            pending_q <= 1'b1;
          end
        end
        default: begin
          next_q    <= ST_TITLE;
          pending_q <= 1'b1;
        end
      endcase
    end
  end

  assign state_out     = state_q;
  assign turn_out      = turn_q;
  assign rotate_out    = rot_q;
  assign game_over_out = game_over_q;
  assign timeout_out   = timeout_q;

endmodule : turn_sequencer

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed walk through a full game followed by
// randomized stimulus, every cycle compared against a reference model.
module tb_turn_sequencer;

  localparam int MT = 3;
  localparam int RF = 2;
  localparam int TF = 4;

  localparam logic [3:0] S_TITLE   = 4'b0001;
  localparam logic [3:0] S_PLAYER  = 4'b0010;
  localparam logic [3:0] S_RESOLVE = 4'b0100;
  localparam logic [3:0] S_ENEMY   = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_frame_in = 1'b0;
  logic       start_btn_in = 1'b1;
  logic       move_valid_in = 1'b0;
  logic       rotate_btn_in = 1'b0;
  logic       player_dead_in = 1'b0;
  logic       enemy_busy_in = 1'b0;
  logic       enemy_finished_in = 1'b0;
  logic [3:0] state_out;
  logic [3:0] turn_out;
  logic [1:0] rotate_out;
  logic       game_over_out;
  logic       timeout_out;

  turn_sequencer #(
    .MAX_TURNS      (MT),
    .RESOLVE_FRAMES (RF),
    .TIMEOUT_FRAMES (TF)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .new_frame_in      (new_frame_in),
    .start_btn_in      (start_btn_in),
    .move_valid_in     (move_valid_in),
    .rotate_btn_in     (rotate_btn_in),
    .player_dead_in    (player_dead_in),
    .enemy_busy_in     (enemy_busy_in),
    .enemy_finished_in (enemy_finished_in),
    .state_out         (state_out),
    .turn_out          (turn_out),
    .rotate_out        (rotate_out),
    .game_over_out     (game_over_out),
    .timeout_out       (timeout_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: game state, a requested-next-state slot, and the
  // number of frames seen since the current state was entered.
  logic [3:0] m_state;
  logic [3:0] m_next;
  bit         m_pending;
  int         m_turn;
  int         m_rot;
  int         m_frames;
  bit         m_go;
  bit         m_to;
  bit         m_start_prev;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_state = S_TITLE; m_next = S_TITLE; m_pending = 0;
    m_turn = 0; m_rot = 0; m_frames = 0; m_go = 0; m_to = 0;
    m_start_prev = 1;
  endfunction

  function automatic void model_step();
    bit apply;
    bit rise;
    apply = m_pending && new_frame_in;
    rise  = start_btn_in && !m_start_prev;
    m_start_prev = start_btn_in;
    if (apply) begin
      if (m_state == S_TITLE) begin
        m_turn = 0; m_rot = 0; m_go = 0; m_to = 0;
      end
      if (m_state == S_ENEMY) m_turn = (m_turn + 1) % MT;
      m_state = m_next; m_pending = 0; m_frames = 0;
    end else begin
      if (new_frame_in && (m_state == S_RESOLVE || m_state == S_ENEMY)) m_frames++;
      if (!m_pending) begin
        case (m_state)
          S_TITLE: if (rise) begin m_next = S_PLAYER; m_pending = 1; end
          S_PLAYER: begin
            if (rotate_btn_in) m_rot = (m_rot + 1) % 4;
            if (move_valid_in) begin m_next = S_RESOLVE; m_pending = 1; end
          end
          S_RESOLVE: if (new_frame_in && m_frames == RF) begin
            m_pending = 1;
            if (player_dead_in) begin m_go = 1; m_next = S_TITLE; end
            else m_next = S_ENEMY;
          end
          S_ENEMY: begin
            if (enemy_finished_in) begin
              m_next = S_PLAYER; m_pending = 1;
            end else if (new_frame_in && m_frames == TF) begin
              m_to = 1; m_next = S_PLAYER; m_pending = 1;
            end
          end
          default: ;
        endcase
      end
    end
  endfunction

  task automatic compare_all();
    chk("state", state_out, m_state);
    chk("turn", turn_out, 8'(m_turn));
    chk("rotate", rotate_out, 8'(m_rot));
    chk("game_over", game_over_out, m_go);
    chk("timeout", timeout_out, m_to);
  endtask

  task automatic clear_pulses();
    cyc++;
    new_frame_in      = (cyc % 10 == 0);
    move_valid_in     = 0;
    rotate_btn_in     = 0;
    enemy_finished_in = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    clear_pulses();
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int limit);
    int n = 0;
    while (state_out !== s && n < limit) begin
      cycle();
      n++;
    end
    chk(tag, state_out, s);
  endtask

  task automatic wait_frame_slot();
    int n = 0;
    while (!new_frame_in && n < 20) begin
      cycle();
      n++;
    end
    chk("frame_slot", new_frame_in, 1);
  endtask

  // Reset asserted between clock edges, held across one edge.
  task automatic async_reset();
    #2;
    rst = 1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    #2;
    rst = 0;
    clear_pulses();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_state", state_out, S_TITLE);
    #2;
    rst = 0;

    // Start held through reset must not start a game.
    repeat (15) cycle();
    chk("title_held", state_out, S_TITLE);
    start_btn_in = 0;
    repeat (3) cycle();
    start_btn_in = 1;
    wait_state("enter_player", S_PLAYER, 30);
    chk("turn_start", turn_out, 0);
    chk("rot_start", rotate_out, 0);

    // Five rotates then a move; a rotate after the move is ignored.
    for (int i = 1; i <= 5; i++) begin
      rotate_btn_in = 1;
      cycle();
      chk("rot_step", rotate_out, 8'(i % 4));
    end
    move_valid_in = 1;
    cycle();
    rotate_btn_in = 1;
    cycle();
    chk("rot_after_move", rotate_out, 1);
    wait_state("enter_resolve", S_RESOLVE, 30);
    player_dead_in = 0;
    wait_state("enter_enemy", S_ENEMY, 40);

    // Finished coinciding with a frame pulse waits for the next frame.
    wait_frame_slot();
    enemy_finished_in = 1;
    cycle();
    repeat (5) cycle();
    chk("enemy_hold", state_out, S_ENEMY);
    wait_state("finish_player", S_PLAYER, 20);
    chk("turn_one", turn_out, 1);

    // Watchdog-ended enemy phase.
    move_valid_in = 1;
    cycle();
    wait_state("resolve2", S_RESOLVE, 30);
    wait_state("enemy2", S_ENEMY, 40);
    wait_state("timeout_player", S_PLAYER, 80);
    chk("timeout_set", timeout_out, 1);
    chk("turn_two", turn_out, 2);

    // Third turn wraps the turn counter.
    move_valid_in = 1;
    cycle();
    wait_state("enemy3", S_ENEMY, 70);
    repeat (3) cycle();
    enemy_finished_in = 1;
    cycle();
    wait_state("wrap_player", S_PLAYER, 20);
    chk("turn_wrap", turn_out, 0);
    chk("timeout_sticky", timeout_out, 1);

    // Player dies during resolve.
    move_valid_in = 1;
    cycle();
    wait_state("resolve4", S_RESOLVE, 30);
    player_dead_in = 1;
    wait_state("dead_title", S_TITLE, 40);
    chk("game_over_set", game_over_out, 1);
    player_dead_in = 0;

    // New game clears the flags.
    start_btn_in = 0;
    cycle();
    start_btn_in = 1;
    wait_state("restart_player", S_PLAYER, 30);
    chk("game_over_clr", game_over_out, 0);
    chk("timeout_clr", timeout_out, 0);

    // Reset mid-enemy with a transition pending.
    move_valid_in = 1;
    cycle();
    wait_state("enemy5", S_ENEMY, 70);
    repeat (4) cycle();
    enemy_finished_in = 1;
    cycle();
    async_reset();
    repeat (40) cycle();
    chk("no_stale", state_out, S_TITLE);

    // Randomized phase.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) start_btn_in = ~start_btn_in;
      if ($urandom_range(0, 29) == 0) player_dead_in = ~player_dead_in;
      move_valid_in     = ($urandom_range(0, 14) == 0);
      rotate_btn_in     = ($urandom_range(0, 5) == 0);
      enemy_finished_in = ($urandom_range(0, 29) == 0);
      enemy_busy_in     = 1'($urandom_range(0, 1));
      cycle();
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_turn_sequencer

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-flow controller sitting directly upstream of the enemy renderer/AI block.
- Generates the game state, turn number and rotation that the enemy block consumes.
- Watches the enemy block's busy/finished handshake to decide when the enemy phase is over.
- Applies every state change only at a frame boundary, so the pixel pipeline never renders a frame that mixes two game states.

Parameters:
- MAX_TURNS, 16, turn_out wraps from MAX_TURNS-1 to 0; must be ≤ 16.
- RESOLVE_FRAMES, 30, number of frame pulses spent in RESOLVE before the outcome is decided; ≥ 1.
- TIMEOUT_FRAMES, 120, frame pulses allowed in ENEMY before the watchdog forces the phase to end; ≥ 1.

Ports:
- clk  in  1  system clock; the single clock for this block.
- rst  in  1  reset; asynchronous, active-high.
- new_frame_in  in  1  one-cycle pulse at the start of each video frame.
- start_btn_in  in  1  debounced start button level; edge-detected internally.
- move_valid_in  in  1  one-cycle pulse: player committed a move.
- rotate_btn_in  in  1  one-cycle pulse: rotate request.
- player_dead_in  in  1  level from the collision logic.
- enemy_busy_in  in  1  enemy block busy flag.
- enemy_finished_in  in  1  enemy block finished pulse or level.
- state_out  out  4  one-hot game state.
- turn_out  out  4  current turn number.
- rotate_out  out  2  current rotation.
- game_over_out  out  1  set when a game ends with the player dead.
- timeout_out  out  1  sticky watchdog flag.

Behaviour:
- State encodings:
  - TITLE = 4'b0001
  - PLAYER = 4'b0010
  - RESOLVE = 4'b0100
  - ENEMY = 4'b1000
  - state_out is always exactly one of these.
- Reset (asynchronous, any time, including mid-phase):
  - state_out = TITLE; turn_out = 0; rotate_out = 0.
  - game_over_out = 0; timeout_out = 0.
  - Pending request cleared; frame and watchdog counters = 0.
  - Start edge detector history = 1, so a button held through reset does not start a game.
- Pending mechanism:
  - A transition request latches a next-state register plus a pending flag at cycle t.
  - state_out takes the new value on the cycle after the first new_frame_in strictly later than t.
  - If new_frame_in coincides with the cycle t itself, the transition waits for the following frame.
  - Only one request can be pending; further triggers are ignored until it is applied.
- TITLE:
  - A rising edge of start_btn_in requests PLAYER.
  - When that transition is applied: turn_out = 0, rotate_out = 0, game_over_out = 0, timeout_out = 0.
- PLAYER:
  - rotate_btn_in increments rotate_out modulo 4, registered with 1-cycle latency.
  - Rotate pulses are ignored once a request is pending.
  - move_valid_in requests RESOLVE.
  - A rotate pulse and a move pulse in the same cycle: both take effect.
- RESOLVE:
  - The frame counter increments on each new_frame_in.
  - On the pulse that brings the count to RESOLVE_FRAMES, player_dead_in is sampled:
    - dead: set game_over_out = 1 and request TITLE;
    - alive: request ENEMY.
  - The frame counter clears on entry to each state.
- ENEMY:
  - enemy_finished_in high on any cycle requests PLAYER; it need not be preceded by busy.
  - The watchdog counts new_frame_in pulses.
  - If the watchdog reaches TIMEOUT_FRAMES with no request pending, set timeout_out = 1 and request PLAYER.
  - finished and the watchdog limit in the same cycle: treated as finished; timeout_out stays unchanged.
  - When the ENEMY→PLAYER transition is applied, turn_out increments, wrapping from MAX_TURNS-1 to 0.
  - enemy_busy_in has no effect on transitions; it is only registered into a debug/visibility flop.
- Boundary rules:
  - Inputs that are invalid for the current state are ignored.
  - start_btn_in edges outside TITLE are ignored.
  - All outputs are registered and change only on clk.

Decomposition:
- game_pkg holds:
  - the four state encodings as a typedef'd enum, also used by the enemy block;
  - default values for MAX_TURNS, RESOLVE_FRAMES and TIMEOUT_FRAMES.
- One sub-module: frame_counter.
  - Counts new_frame_in pulses, with a synchronous clear and a terminal-count output at a parameterised limit.
  - Instantiated once for the RESOLVE counter and once for the watchdog.
- The start edge detector stays inline.

Test Plan (bench parameters: RESOLVE_FRAMES=2, TIMEOUT_FRAMES=4, MAX_TURNS=3; frame pulse every 10 cycles):
- Reset with start_btn_in held high, then release and press → state_out stays 4'b0001 until the fresh edge; it becomes 4'b0010 one cycle after the next frame pulse, with turn_out=0 and rotate_out=0.
- In PLAYER, 5 rotate pulses then move_valid_in → rotate_out reads 1,2,3,0,1; state_out becomes 4'b0100 after the next frame pulse; a rotate pulse after the move leaves rotate_out=1.
- RESOLVE with player_dead_in=0 → after 2 frame pulses, ENEMY is requested; state_out=4'b1000 on the frame after that. With player_dead_in=1 → game_over_out=1 and state_out returns to 4'b0001.
- In ENEMY, pulse enemy_finished_in on the same cycle as new_frame_in → transition applies on the next frame, not the current one; state_out=4'b0010 and turn_out increments 0→1.
- In ENEMY, never assert finished → after 4 frame pulses timeout_out=1; PLAYER is entered on the following frame; three full turns wrap turn_out 2→0.
- Assert rst for 1 cycle mid-ENEMY, asynchronously between clock edges → all outputs show reset values immediately, and no stale pending transition is applied afterwards.
